// File: rtl/ghash_tag_engine.sv
// GHASH accumulator and GCM tag generator.
// Blocks are folded into Y with a digit-serial GF(2^128) multiplier. The engine then appends the
// {aad_bits, data_bits} length block itself and emits tag = GHASH xor E_K(Y0).
module ghash_tag_engine #(
  parameter int unsigned DIGIT_W = 8,
  parameter int unsigned CNT_W   = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] h_key,
  input  logic         h_load,
  input  logic [127:0] ek_y0,
  input  logic         ek_load,
  input  logic         start,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_data,
  input  logic [4:0]   blk_bytes,
  input  logic         blk_type,
  input  logic         blk_last,
  output logic [127:0] tag,
  output logic [127:0] ghash_out,
  output logic         tag_valid,
  input  logic         tag_ready,
  output logic         busy,
  output logic         err
);

  localparam int unsigned NCYC = 128 / DIGIT_W;
  localparam logic [127:0] R_POLY = {8'he1, 120'd0};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACCUM = 3'd1;
  localparam logic [2:0] S_MULT  = 3'd2;
  localparam logic [2:0] S_LEN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  if (DIGIT_W != 1 && DIGIT_W != 2 && DIGIT_W != 4 && DIGIT_W != 8 && DIGIT_W != 16 &&
      DIGIT_W != 32 && DIGIT_W != 64 && DIGIT_W != 128) begin : g_bad_digit
    $fatal(1, "ghash_tag_engine: DIGIT_W must be a power of two from 1 to 128");
  end
  if (CNT_W < 1 || CNT_W > 64) begin : g_bad_cnt
    $fatal(1, "ghash_tag_engine: CNT_W must be 1..64");
  end

  logic [2:0]       state;
  logic [127:0]     y, h, ek, x, z, v;
  logic [CNT_W-1:0] aad_bits, data_bits;
  logic [7:0]       cnt;
  logic             len_phase, last_blk, seen_ct, aad_part, data_part;

  logic [127:0] z_nxt, v_nxt, mask, lens, ek_eff;
  logic [7:0]   pad_bits, blk_bits;
  logic         viol, mult_done;

  // Unrolled DIGIT_W steps of the bit-serial multiply, X consumed MSB first.
  always_comb begin
    z_nxt = z;
    v_nxt = v;
    for (int i = 0; i < DIGIT_W; i++) begin
      if (x[127-i]) z_nxt = z_nxt ^ v_nxt;
      v_nxt = (v_nxt >> 1) ^ ({128{v_nxt[0]}} & R_POLY);
    end
  end

  // Block masking, protocol checks and misc decode.
  always_comb begin
    blk_bits  = {blk_bytes, 3'b000};
    pad_bits  = 8'd128 - blk_bits;
    mask      = {128{1'b1}} << pad_bits;
    lens      = {64'(aad_bits), 64'(data_bits)};
    viol      = (!blk_type && seen_ct) || (blk_type ? data_part : aad_part) ||
                (blk_bytes == 5'd0 && !blk_last) || (blk_bytes > 5'd16);
    mult_done = (state == S_MULT) && (cnt == 8'(NCYC - 1));
    // A key arriving on the DONE-entry edge must already feed the tag.
    ek_eff    = ek_load ? ek_y0 : ek;
  end

  assign blk_ready = (state == S_ACCUM);
  assign tag_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // Main state machine and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      y         <= '0;
      h         <= '0;
      ek        <= '0;
      x         <= '0;
      z         <= '0;
      v         <= '0;
      aad_bits  <= '0;
      data_bits <= '0;
      cnt       <= '0;
      len_phase <= 1'b0;
      last_blk  <= 1'b0;
      seen_ct   <= 1'b0;
      aad_part  <= 1'b0;
      data_part <= 1'b0;
      tag       <= '0;
      ghash_out <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (h_load && (state == S_IDLE || state == S_DONE)) h <= h_key;
      if (ek_load && state != S_DONE) ek <= ek_y0;
      if (start) begin
        state     <= S_ACCUM;
        y         <= '0;
        aad_bits  <= '0;
        data_bits <= '0;
        len_phase <= 1'b0;
        last_blk  <= 1'b0;
        seen_ct   <= 1'b0;
        aad_part  <= 1'b0;
        data_part <= 1'b0;
      end else begin
        case (state)
          S_ACCUM: begin
            if (blk_valid) begin
              if (viol) begin
                err <= 1'b1;
              end else begin
                if (blk_type) begin
                  data_bits <= data_bits + CNT_W'(blk_bits);
                  data_part <= (blk_bytes < 5'd16);
                  seen_ct   <= 1'b1;
                end else begin
                  aad_bits <= aad_bits + CNT_W'(blk_bits);
                  aad_part <= (blk_bytes < 5'd16);
                end
                x         <= y ^ (blk_data & mask);
                z         <= '0;
                v         <= h;
                cnt       <= '0;
                last_blk  <= blk_last;
                len_phase <= 1'b0;
                // Empty final block skips straight to the length block.
                state     <= (blk_bytes == 5'd0) ? S_LEN : S_MULT;
              end
            end
          end
          S_MULT: begin
            z   <= z_nxt;
            v   <= v_nxt;
            x   <= x << DIGIT_W;
            cnt <= cnt + 8'd1;
            if (mult_done) begin
              y <= z_nxt;
              if (len_phase) begin
                state     <= S_DONE;
                ghash_out <= z_nxt;
                tag       <= z_nxt ^ ek_eff;
              end else begin
                state <= last_blk ? S_LEN : S_ACCUM;
              end
            end
          end
          S_LEN: begin
            x         <= y ^ lens;
            z         <= '0;
            v         <= h;
            cnt       <= '0;
            len_phase <= 1'b1;
            state     <= S_MULT;
          end
          S_DONE: begin
            if (tag_ready) state <= S_IDLE;
          end
          S_IDLE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ghash_tag_engine.sv
// Directed bench for ghash_tag_engine: GCM known-answer vectors at several digit widths,
// latency, backpressure, abort, protocol errors and mid-run reset.
module tb_ghash_tag_engine;

  localparam logic [127:0] H1  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] EK1 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] C2  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] G2  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam logic [127:0] T2  = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam logic [127:0] H2  = 128'hb83b533708bf535d0aa6e52980d53b78;
  localparam logic [127:0] EK2 = 128'h3247184b3c4f69a44dbcd22887bbb418;
  localparam logic [127:0] T4  = 128'h5bc94fbc3221a5db94fae95ae7121a47;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [127:0] h_key = '0, ek_y0 = '0, blk_data = '0;
  logic         h_load = 1'b0, ek_load = 1'b0, tag_ready = 1'b0, blk_type = 1'b0;
  logic         blk_last = 1'b0;
  logic [4:0]   blk_bytes = '0;
  logic [3:0]   start_v = '0, valid_v = '0;
  logic [3:0]   ready_w, tv_w, busy_w, err_w;
  logic [127:0] tag_w [4];
  logic [127:0] ghash_w [4];

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ghash_tag_engine #(
      .DIGIT_W(g == 0 ? 8 : g == 1 ? 1 : g == 2 ? 32 : 128),
      .CNT_W  (64)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .h_key    (h_key),
      .h_load   (h_load),
      .ek_y0    (ek_y0),
      .ek_load  (ek_load),
      .start    (start_v[g]),
      .blk_valid(valid_v[g]),
      .blk_ready(ready_w[g]),
      .blk_data (blk_data),
      .blk_bytes(blk_bytes),
      .blk_type (blk_type),
      .blk_last (blk_last),
      .tag      (tag_w[g]),
      .ghash_out(ghash_w[g]),
      .tag_valid(tv_w[g]),
      .tag_ready(tag_ready),
      .busy     (busy_w[g]),
      .err      (err_w[g])
    );
  end

  function automatic int ncyc(input int d);
    return (d == 0) ? 16 : (d == 1) ? 128 : (d == 2) ? 4 : 1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic chkb(input string name, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", name, obs, exp);
    end
  endtask

  task automatic wait_ready(input int d);
    int k = 0;
    while (ready_w[d] !== 1'b1 && k < 600) begin
      tick;
      k++;
    end
    if (ready_w[d] !== 1'b1) chkb("ready_timeout", ready_w[d], 1'b1);
  endtask

  task automatic send(input int d, input logic [127:0] data, input logic [4:0] bytes,
                      input logic typ, input logic last);
    wait_ready(d);
    blk_data   = data;
    blk_bytes  = bytes;
    blk_type   = typ;
    blk_last   = last;
    valid_v[d] = 1'b1;
    tick;
    valid_v = '0;
  endtask

  // Cycles from the handshake cycle to the first cycle showing the awaited output.
  task automatic wait_lat(input int d, input logic want_tv, output int l);
    l = 1;
    while (((want_tv ? tv_w[d] : ready_w[d]) !== 1'b1) && l < 1000) begin
      tick;
      l++;
    end
  endtask

  task automatic pulse_start(input int d);
    start_v[d] = 1'b1;
    tick;
    start_v = '0;
  endtask

  task automatic load_keys(input logic [127:0] hk, input logic [127:0] ek);
    h_key   = hk;
    ek_y0   = ek;
    h_load  = 1'b1;
    ek_load = 1'b1;
    tick;
    h_load  = 1'b0;
    ek_load = 1'b0;
  endtask

  task automatic consume(input int d);
    tag_ready = 1'b1;
    tick;
    tag_ready = 1'b0;
    chkb("tv_after_consume", tv_w[d], 1'b0);
  endtask

  task automatic run_tc4(input int d, input logic inject);
    int l;
    pulse_start(d);
    send(d, 128'hfeedfacedeadbeeffeedfacedeadbeef, 5'd16, 1'b0, 1'b0);
    wait_lat(d, 1'b0, l);
    chk("blk_to_ready_lat", 128'(l), 128'(ncyc(d) + 1));
    // Trailing bytes are junk and must be masked off.
    send(d, 128'habaddad2_0123456789abcdef_01234567, 5'd4, 1'b0, 1'b0);
    send(d, 128'h42831ec2217774244b7221b784d0d49c, 5'd16, 1'b1, 1'b0);
    if (inject) begin
      send(d, 128'h11111111222222223333333344444444, 5'd16, 1'b0, 1'b0);
      chkb("err_aad_after_ct", err_w[d], 1'b1);
      chkb("err_keeps_accum", ready_w[d], 1'b1);
      tick;
      chkb("err_one_cycle", err_w[d], 1'b0);
    end
    send(d, 128'he3aa212f2c02a4e035c17e2329aca12e, 5'd16, 1'b1, 1'b0);
    send(d, 128'h21d514b25466931c7d8f6a5aac84aa05, 5'd16, 1'b1, 1'b0);
    send(d, 128'h1ba30b396a0aac973d58e091_cafef00d, 5'd12, 1'b1, 1'b1);
    wait_lat(d, 1'b1, l);
    chk("tc4_last_lat", 128'(l), 128'(2 * ncyc(d) + 2));
    chk("tc4_tag", tag_w[d], T4);
    chk("tc4_ghash", ghash_w[d], T4 ^ EK2);
    consume(d);
  endtask

  initial begin
    repeat (2) tick;
    rst = 1'b0;
    chk("rst_tag", tag_w[0], '0);
    chk("rst_ghash", ghash_w[0], '0);
    chkb("rst_tv", tv_w[0], 1'b0);
    chkb("rst_ready", ready_w[0], 1'b0);
    chkb("rst_busy", busy_w[0], 1'b0);
    chkb("rst_err", err_w[0], 1'b0);

    // Scenario 1: empty final block.
    load_keys(H1, EK1);
    pulse_start(0);
    chkb("accum_ready", ready_w[0], 1'b1);
    chkb("accum_busy", busy_w[0], 1'b1);
    send(0, 128'hffffffffffffffffffffffffffffffff, 5'd0, 1'b1, 1'b1);
    wait_lat(0, 1'b1, lat);
    chk("empty_lat", 128'(lat), 128'd18);
    chk("empty_ghash", ghash_w[0], '0);
    chk("empty_tag", tag_w[0], EK1);
    consume(0);
    chkb("idle_busy", busy_w[0], 1'b0);

    // Scenario 2 with tag backpressure.
    pulse_start(0);
    send(0, C2, 5'd16, 1'b1, 1'b1);
    wait_lat(0, 1'b1, lat);
    chk("tc2_lat", 128'(lat), 128'd34);
    chk("tc2_ghash", ghash_w[0], G2);
    chk("tc2_tag", tag_w[0], T2);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_tag_stable", tag_w[0], T2);
      chkb("bp_ready_low", ready_w[0], 1'b0);
      chkb("bp_tv_high", tv_w[0], 1'b1);
    end
    consume(0);

    // Abort mid-multiply, then rerun scenario 2.
    pulse_start(0);
    send(0, C2, 5'd16, 1'b1, 1'b0);
    repeat (5) tick;
    chkb("mid_mult_ready", ready_w[0], 1'b0);
    pulse_start(0);
    chkb("abort_ready", ready_w[0], 1'b1);
    send(0, C2, 5'd16, 1'b1, 1'b1);
    wait_lat(0, 1'b1, lat);
    chk("abort_rerun_tag", tag_w[0], T2);
    // start together with tag_ready in DONE goes straight to a fresh run.
    start_v[0] = 1'b1;
    tag_ready  = 1'b1;
    tick;
    start_v   = '0;
    tag_ready = 1'b0;
    chkb("start_consume_tv", tv_w[0], 1'b0);
    chkb("start_consume_ready", ready_w[0], 1'b1);
    send(0, '0, 5'd0, 1'b1, 1'b1);
    wait_lat(0, 1'b1, lat);
    chk("cleared_run_tag", tag_w[0], EK1);
    consume(0);

    // Scenario 3 across digit widths, with an injected error on the first.
    load_keys(H2, EK2);
    run_tc4(0, 1'b1);
    run_tc4(1, 1'b0);
    run_tc4(2, 1'b0);
    run_tc4(3, 1'b0);

    // Protocol errors.
    pulse_start(0);
    send(0, 128'h0123456789abcdef0123456789abcdef, 5'd12, 1'b1, 1'b0);
    send(0, 128'h0123456789abcdef0123456789abcdef, 5'd16, 1'b1, 1'b0);
    chkb("err_after_partial", err_w[0], 1'b1);
    pulse_start(0);
    send(0, '0, 5'd0, 1'b0, 1'b0);
    chkb("err_zero_not_last", err_w[0], 1'b1);
    send(0, '0, 5'd17, 1'b0, 1'b1);
    chkb("err_bytes_17", err_w[0], 1'b1);
    send(0, '0, 5'd0, 1'b0, 1'b1);
    chkb("no_err_empty_last", err_w[0], 1'b0);
    wait_lat(0, 1'b1, lat);
    chk("err_dropped_tag", tag_w[0], EK2);
    consume(0);

    // Reset while in the length phase.
    pulse_start(0);
    send(0, C2, 5'd16, 1'b1, 1'b1);
    repeat (16) tick;
    chkb("in_len_busy", busy_w[0], 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_tag", tag_w[0], '0);
    chk("mid_rst_ghash", ghash_w[0], '0);
    chkb("mid_rst_tv", tv_w[0], 1'b0);
    chkb("mid_rst_busy", busy_w[0], 1'b0);
    chkb("mid_rst_ready", ready_w[0], 1'b0);
    chkb("mid_rst_err", err_w[0], 1'b0);
    pulse_start(0);
    send(0, C2, 5'd16, 1'b1, 1'b1);
    wait_lat(0, 1'b1, lat);
    chk("zero_key_tag", tag_w[0], '0);
    consume(0);
    load_keys(H1, EK1);
    pulse_start(0);
    send(0, C2, 5'd16, 1'b1, 1'b1);
    wait_lat(0, 1'b1, lat);
    chk("reloaded_tag", tag_w[0], T2);
    consume(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ghash_tag_engine.md
Name: ghash_tag_engine

Overview:
- Parametrised GHASH and tag engine for the AES-GCM datapath.
- Accepts 128-bit AAD and ciphertext blocks and accumulates Y_i = (Y_{i-1} xor X_i)·H over GF(2^128) with a digit-serial multiplier.
- Appends the bit-length block itself and emits tag = GHASH xor E_K(Y0).
- Sits downstream of the AES-CTR core and upstream of the scoreboard-checked output stream.

Parameters:
- DIGIT_W, 8: bits of X consumed per multiply cycle. Legal values are 1, 2, 4, 8, 16, 32, 64, 128; any other value is a fatal elaboration error.
- CNT_W, 64: width of each of the AAD and data bit-length counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- h_key  in  128  hash subkey H = E_K(0^128).
- h_load  in  1  capture h_key; honoured only in IDLE or DONE.
- ek_y0  in  128  E_K(Y0).
- ek_load  in  1  capture ek_y0; honoured in any state except DONE.
- start  in  1  clear Y and both length counters, enter ACCUM. Aborts any run in progress.
- blk_valid  in  1  block offered.
- blk_ready  out  1  engine can take a block.
- blk_data  in  128  block data, MSB-aligned; byte 0 sits in bits 127:120.
- blk_bytes  in  5  number of valid bytes, 0..16. The value 0 is legal only with blk_last.
- blk_type  in  1  0 = AAD, 1 = ciphertext.
- blk_last  in  1  final block of the message.
- tag  out  128  authentication tag.
- ghash_out  out  128  final GHASH value before the xor with ek.
- tag_valid  out  1  tag and ghash_out are valid.
- tag_ready  in  1  tag consumed.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset: state=IDLE. tag, ghash_out, Y, H, ek and both counters = 0. blk_ready, tag_valid, busy and err = 0.
- States and transitions:
  - IDLE: start -> ACCUM.
  - ACCUM: blk_ready=1. On a handshake:
    - bytes beyond blk_bytes are zeroed;
    - X = Y xor masked data;
    - the counter selected by blk_type increments by blk_bytes*8, wrapping mod 2^CNT_W;
    - next state is MULT.
    - If blk_bytes=0 and blk_last=1, no multiply is done and the next state is LEN.
  - MULT: runs exactly 128/DIGIT_W cycles, then Y = X·H. Next state is LEN if the accepted block had last=1, otherwise ACCUM.
  - LEN: X = Y xor {aad_bits, data_bits}. Runs one multiply of 128/DIGIT_W cycles, then DONE.
  - DONE: on entry, ghash_out = Y and tag = Y xor ek; tag_valid=1. Both outputs are held stable until tag_ready, then state -> IDLE and tag_valid=0.
- Multiply, per iteration, consuming X bits leftmost (bit 127) first:
  - if the current bit is 1, Z ^= V;
  - then V = V>>1, xor 0xE1<<120 if the shifted-out bit was 1;
  - Z starts at 0 and V starts at H;
  - DIGIT_W iterations are unrolled per cycle.
- Latency:
  - block handshake to blk_ready re-asserted = 128/DIGIT_W + 1 cycles;
  - last handshake to tag_valid = 2·(128/DIGIT_W) + 2 cycles;
  - empty-last handshake to tag_valid = 128/DIGIT_W + 2 cycles.
- Protocol errors: each one pulses err, drops the block (no counter or Y update), and leaves the state unchanged:
  - AAD block after any ciphertext block;
  - a block following a partial (blk_bytes<16) block of the same type;
  - blk_bytes=0 without blk_last;
  - blk_bytes>16.
- start in any state other than IDLE aborts the current run and re-enters ACCUM with cleared Y and counters; tag_valid drops. H and ek are retained.
- start and rst asserted together: rst wins.
- Simultaneous tag_ready and start in DONE: tag is consumed and the next state is ACCUM.
- ek_load in the same cycle as entry to DONE: the new ek is used.
- Reset mid-operation returns every output to its reset value on the next edge.

Test Plan:
1. DIGIT_W=8; H=66e94bd4ef8a2c3b884cfa59ca342b2e, ek=58e2fccefa7e3061367f1d57a4e7455a; start, then one block with bytes=0, last=1 -> ghash_out=0, tag=58e2fccefa7e3061367f1d57a4e7455a, tag_valid 18 cycles after the handshake.
2. Same H and ek; one ciphertext block 0388dace60b6a392f328c2b971b2fe78 with bytes=16, last=1 -> ghash_out=f38cbb1ad69223dcc3457ae5b6b0f885, tag=ab6e47d42cec13bdf53a67b21257bddf, tag_valid 34 cycles after the handshake.
3. H=b83b533708bf535d0aa6e52980d53b78, ek=3247184b3c4f69a44dbcd22887bbb418. Send in order:
   - AAD feedfacedeadbeeffeedfacedeadbeef, bytes=16;
   - AAD abaddad2…, bytes=4;
   - ciphertext 42831ec2217774244b7221b784d0d49c, e3aa212f2c02a4e035c17e2329aca12e and 21d514b25466931c7d8f6a5aac84aa05, each bytes=16;
   - ciphertext 1ba30b396a0aac973d58e091…, bytes=12, last=1.
   Required: tag=5bc94fbc3221a5db94fae95ae7121a47. Repeat for DIGIT_W=1, 32 and 128 -> identical tag, and MULT duration of 128, 4 and 1 cycles respectively.
4. Backpressure and abort: hold tag_ready=0 for 10 cycles -> tag stable and blk_ready=0 throughout. Assert start mid-MULT, then rerun scenario 2 -> same tag as scenario 2.
5. Errors: inside scenario 3, inject an AAD block after the first ciphertext block -> one err pulse, tag unchanged. Also inject a ciphertext block after the 12-byte partial block -> err pulse.
6. Assert rst for one cycle during LEN -> all outputs at reset values. H reads 0, so a run must reload H before its tag is valid.
